// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register-file read, writeback bypass, immediate
// generation, load-use stall and the ID/EX pipeline register with valid/ready and flush.
module id_stage #(
  parameter int NumEntries = 32,
  parameter int XLEN       = 32
) (
  input  logic                                clk_100MHz,
  input  logic                                reset,
  input  logic                                if_valid,
  input  logic [31:0]                         if_instr,
  input  logic [XLEN-1:0]                     if_pc,
  output logic                                id_ready,
  input  logic                                flush,
  output logic                                readEn,
  output logic [$clog2(NumEntries<<2)-1:0]    readAddr,
  input  logic [XLEN-1:0]                     readData,
  output logic                                readEn_2,
  output logic [$clog2(NumEntries<<2)-1:0]    readAddr_2,
  input  logic [XLEN-1:0]                     readData_2,
  input  logic                                wb_we,
  input  logic [4:0]                          wb_rd,
  input  logic [XLEN-1:0]                     wb_data,
  input  logic                                ex_ready,
  output logic                                ex_valid,
  output logic [XLEN-1:0]                     ex_pc,
  output logic [XLEN-1:0]                     ex_imm,
  output logic [XLEN-1:0]                     ex_rs1_val,
  output logic [XLEN-1:0]                     ex_rs2_val,
  output logic [4:0]                          ex_rs1,
  output logic [4:0]                          ex_rs2,
  output logic [4:0]                          ex_rd,
  output logic [6:0]                          ex_opcode,
  output logic [2:0]                          ex_funct3,
  output logic                                ex_funct7b5,
  output logic                                ex_illegal
);

  localparam int AW = $clog2(NumEntries << 2);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  opcode_e         opcode;
  logic [4:0]      rs1, rs2, rd;
  logic            uses_rs1, uses_rs2, illegal;
  logic [XLEN-1:0] imm, rs1_val, rs2_val;
  logic            load_use, advance;

  assign opcode = opcode_e'(if_instr[6:0]);
  assign rs1    = if_instr[19:15];
  assign rs2    = if_instr[24:20];
  assign rd     = if_instr[11:7];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    imm      = '0;
    case (opcode)
      OPC_OP: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        uses_rs1 = 1'b1;
        imm      = {{20{if_instr[31]}}, if_instr[31:20]};
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        imm      = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: imm = {if_instr[31:12], 12'b0};
      OPC_JAL: imm = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                      if_instr[20], if_instr[30:21], 1'b0};
      default: illegal = 1'b1;
    endcase
  end

  assign readEn     = if_valid & uses_rs1;
  assign readEn_2   = if_valid & uses_rs2;
  assign readAddr   = if_valid ? AW'(rs1) : '0;
  assign readAddr_2 = if_valid ? AW'(rs2) : '0;

  // Writeback lands in the RF at the next edge, so same-cycle writes are forwarded here.
  always_comb begin
    rs1_val = '0;
    rs2_val = '0;
    if (uses_rs1 && rs1 != 5'd0)
      rs1_val = (wb_we && wb_rd == rs1) ? wb_data : readData;
    if (uses_rs2 && rs2 != 5'd0)
      rs2_val = (wb_we && wb_rd == rs2) ? wb_data : readData_2;
  end

  assign load_use = ex_valid && (ex_opcode == OPC_LOAD) && (ex_rd != 5'd0) &&
                    ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
  assign advance  = !ex_valid || ex_ready;
  assign id_ready = advance && !load_use && !reset;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_imm      <= '0;
      ex_rs1_val  <= '0;
      ex_rs2_val  <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_illegal  <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance) begin
      // A blocked instruction leaves a bubble; payload holds until the next capture.
      if (if_valid && !load_use) begin
        ex_valid    <= 1'b1;
        ex_pc       <= if_pc;
        ex_imm      <= imm;
        ex_rs1_val  <= rs1_val;
        ex_rs2_val  <= rs2_val;
        ex_rs1      <= rs1;
        ex_rs2      <= rs2;
        ex_rd       <= rd;
        ex_opcode   <= opcode;
        ex_funct3   <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
        ex_illegal  <= illegal;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule
